// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bus; the master side (fetch_unit) drives the PC and the output beat.
interface fetch_unit_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9
);
    logic               en;
    logic               redirect_valid;
    logic               out_valid;
    logic               out_ready;
    logic               halted;
    logic [ADDR_W-1:0]  pc_address;
    logic [ADDR_W-1:0]  redirect_target;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] instruction;
    logic [INSTR_W-1:0] out_instr;
    logic [2:0]         out_op;
    logic [2:0]         out_ra;
    logic [2:0]         out_rb;

    modport master (
        input  en, instruction, redirect_valid, redirect_target, out_ready,
        output pc_address, out_valid, out_instr, out_pc, out_op, out_ra, out_rb, halted
    );
    modport slave (
        output en, instruction, redirect_valid, redirect_target, out_ready,
        input  pc_address, out_valid, out_instr, out_pc, out_op, out_ra, out_rb, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and registered instruction fetch with redirect; FETCH_HALT_AT_END_EN adds halt at end of memory.
module fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 9,
    parameter int RESET_PC = 0
) (
    input logic        clk,
    input logic        rst_n,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  out_pc_q;
    logic [INSTR_W-1:0] out_instr_q;
    logic               out_valid_q;
    logic               halted_q;
    logic               fire;
    logic               at_end;

`ifdef FETCH_HALT_AT_END_EN
    assign at_end = pc_q == '1;
`else
    assign at_end = 1'b0;
`endif

    // en gates fire directly so no fetch starts on the edge where en is first seen low
    assign fire = state_q == RUN && bus.en && !bus.redirect_valid && (!out_valid_q || bus.out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= ADDR_W'(RESET_PC);
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            halted_q    <= 1'b0;
        end else if (bus.redirect_valid) begin
            state_q     <= bus.en ? RUN : IDLE;
            pc_q        <= bus.redirect_target;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            if (fire) begin
                out_instr_q <= bus.instruction;
                out_pc_q    <= pc_q;
                out_valid_q <= 1'b1;
                pc_q        <= at_end ? pc_q : pc_q + ADDR_W'(1);
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            state_q  <= (fire && at_end) || state_q == HALT ? HALT : bus.en ? RUN : IDLE;
            halted_q <= halted_q || (fire && at_end);
        end
    end

    assign bus.pc_address = pc_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_instr  = out_instr_q;
    assign bus.out_pc     = out_pc_q;
    assign bus.out_op     = out_instr_q[8:6];
    assign bus.out_ra     = out_instr_q[5:3];
    assign bus.out_rb     = out_instr_q[2:0];
    assign bus.halted     = halted_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a stream scoreboard checked every cycle plus literal spot checks.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    logic armed = 1'b0;
    logic [8:0] mem [256];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(8), .INSTR_W(9)) bus ();

    fetch_unit #(.ADDR_W(8), .INSTR_W(9), .RESET_PC(0)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    assign bus.instruction = mem[bus.pc_address];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!bus.out_valid && n < max) begin
            step();
            n++;
        end
        chk("wait_valid", 32'(bus.out_valid), 1);
    endtask

    // scoreboard: accepted beats must form the sequential address stream, restarted by redirect/reset
    logic [7:0] exp_next = 8'h00;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_pc, prev_addr;
    logic [8:0] prev_instr;

    always @(negedge clk) begin
        if (armed) begin
            if (rst_n === 1'b1) begin
                chk("pc_known", 32'($isunknown(bus.pc_address)), 0);
                if (prev_stall) begin
                    chk("hold_valid", 32'(bus.out_valid), 1);
                    chk("hold_pc", 32'(bus.out_pc), 32'(prev_pc));
                    chk("hold_instr", 32'(bus.out_instr), 32'(prev_instr));
                    chk("hold_addr", 32'(bus.pc_address), 32'(prev_addr));
                end
                if (bus.out_valid) begin
                    chk("instr_mem", 32'(bus.out_instr), 32'(mem[bus.out_pc]));
                    chk("fields", 32'({bus.out_op, bus.out_ra, bus.out_rb}), 32'(mem[bus.out_pc]));
                    if (bus.out_ready) begin
                        chk("seq", 32'(bus.out_pc), 32'(exp_next));
                        exp_next = exp_next + 8'd1;
                    end
                end
                if (bus.redirect_valid) exp_next = bus.redirect_target;
`ifndef FETCH_HALT_AT_END_EN
                chk("halted_zero", 32'(bus.halted), 0);
`endif
                prev_stall = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
                prev_pc    = bus.out_pc;
                prev_instr = bus.out_instr;
                prev_addr  = bus.pc_address;
            end else begin
                exp_next   = 8'h00;
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 9'(i) ^ 9'h0a5;
        mem[0] = 9'b000_000_001;
        mem[1] = 9'b001_010_011;
        mem[2] = 9'b010_001_100;
        mem[5] = 9'b101_001_000;
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_target = 8'h00;
        step();
        step();
        armed = 1'b1;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_addr", 32'(bus.pc_address), 0);
        chk("rst_instr", 32'(bus.out_instr), 0);
        chk("rst_pc", 32'(bus.out_pc), 0);
        chk("rst_halted", 32'(bus.halted), 0);
        // first beats after reset
        rst_n = 1'b1;
        bus.en = 1'b1;
        wait_valid(8);
        chk("t1_pc0", 32'(bus.out_pc), 0);
        chk("t1_op", 32'(bus.out_op), 0);
        chk("t1_ra", 32'(bus.out_ra), 0);
        chk("t1_rb", 32'(bus.out_rb), 1);
        step();
        chk("t1_pc1", 32'(bus.out_pc), 1);
        chk("t1_instr1", 32'(bus.out_instr), 32'(9'b001_010_011));
        step();
        chk("t2_pc2", 32'(bus.out_pc), 2);
        // backpressure
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_stall_pc", 32'(bus.out_pc), 2);
            chk("t2_stall_instr", 32'(bus.out_instr), 32'(9'b010_001_100));
            chk("t2_stall_addr", 32'(bus.pc_address), 3);
        end
        bus.out_ready = 1'b1;
        step();
        chk("t2_next_pc", 32'(bus.out_pc), 3);
        chk("t2_next_valid", 32'(bus.out_valid), 1);
        // redirect discards the stalled beat
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 8'h05;
        step();
        bus.redirect_valid = 1'b0;
        chk("t3_drop", 32'(bus.out_valid), 0);
        step();
        chk("t3_valid", 32'(bus.out_valid), 1);
        chk("t3_pc", 32'(bus.out_pc), 5);
        chk("t3_instr", 32'(bus.out_instr), 32'(9'b101_001_000));
        bus.out_ready = 1'b1;
        // end of memory
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 8'hfe;
        step();
        bus.redirect_valid = 1'b0;
        wait_valid(4);
        chk("t4_fe", 32'(bus.out_pc), 32'h fe);
        step();
        chk("t4_ff", 32'(bus.out_pc), 32'h ff);
`ifdef FETCH_HALT_AT_END_EN
        chk("t4_halted", 32'(bus.halted), 1);
        step();
        chk("t4_drained", 32'(bus.out_valid), 0);
        chk("t4_addr_hold", 32'(bus.pc_address), 32'h ff);
        step();
        step();
        chk("t4_still_halted", 32'(bus.halted), 1);
        chk("t4_still_idle", 32'(bus.out_valid), 0);
        chk("t4_still_addr", 32'(bus.pc_address), 32'h ff);
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 8'h00;
        step();
        bus.redirect_valid = 1'b0;
        chk("t4_unhalt", 32'(bus.halted), 0);
        wait_valid(4);
        chk("t4_resume", 32'(bus.out_pc), 0);
`else
        chk("t4_no_halt", 32'(bus.halted), 0);
        step();
        chk("t4_wrap0", 32'(bus.out_pc), 0);
        step();
        chk("t4_wrap1", 32'(bus.out_pc), 1);
`endif
        // reset mid-stream
        bus.redirect_valid = 1'b1;
        bus.redirect_target = 8'h04;
        step();
        bus.redirect_valid = 1'b0;
        wait_valid(4);
        chk("t5_pc4", 32'(bus.out_pc), 4);
        step();
        chk("t5_pc5", 32'(bus.out_pc), 5);
        chk("t5_addr6", 32'(bus.pc_address), 6);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_rst_valid", 32'(bus.out_valid), 0);
        chk("t5_rst_addr", 32'(bus.pc_address), 0);
        step();
        chk("t5_idle_valid", 32'(bus.out_valid), 0);
        chk("t5_idle_addr", 32'(bus.pc_address), 0);
        wait_valid(4);
        chk("t5_restart", 32'(bus.out_pc), 0);
        step();
        step();
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step();
        chk("t5_glitch_pc", 32'(bus.out_pc), 3);
        chk("t5_glitch_valid", 32'(bus.out_valid), 1);
        // en dropped with a stalled beat pending
        bus.out_ready = 1'b0;
        bus.en = 1'b0;
        step();
        chk("t6_hold_pc", 32'(bus.out_pc), 3);
        chk("t6_hold_addr", 32'(bus.pc_address), 4);
        step();
        bus.out_ready = 1'b1;
        step();
        chk("t6_drain", 32'(bus.out_valid), 0);
        step();
        chk("t6_idle", 32'(bus.out_valid), 0);
        chk("t6_addr", 32'(bus.pc_address), 4);
        bus.en = 1'b1;
        wait_valid(4);
        chk("t6_resume", 32'(bus.out_pc), 4);
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
